// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage and the decoder side:
//   RESET_VECTOR  - first fetch address after reset
//   NOP_INSTR     - instruction word presented to the decoder on a bubble
//   fetch_state_e - fetch FSM state encoding
//   fetch_word_t  - an instruction word paired with its PC+4
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,  // request outstanding to instruction memory
        ST_HOLD  = 1'b1   // word buffered in the skid register, no request
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
    } fetch_word_t;

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: loads a fetched word, holds, or flushes to a NOP
// bubble. Flush wins over load.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - capture din and mark the entry valid
//   flush        - replace the instruction with NOP and clear valid
//   din          - instruction word and its PC+4
//   instruction  - registered instruction to the decoder
//   pc_plus4     - registered PC+4 of that instruction
//   valid        - instruction is a real fetched word
// ----------------------------------------------------------------------------
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  fetch_word_t din,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_INSTR;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            // pc_plus4 is left as-is; it is meaningless while valid is low.
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= din.instruction;
            pc_plus4    <= din.pc_plus4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC, a one-entry skid register and a two-state
// FSM (FETCH / HOLD), and feeds the IF/ID register.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   stall             - hazard hold request; IF/ID freezes while high
//   branch_taken      - single-cycle redirect pulse, highest priority
//   branch_target     - redirect byte address (bits [1:0] ignored)
//   imem_req          - instruction memory request
//   imem_addr         - requested byte address (equals pc)
//   imem_ack          - memory returns imem_data this cycle
//   imem_data         - instruction word from memory
//   pc                - current fetch address
//   ifid_instruction  - registered instruction to the decoder
//   ifid_pc_plus4     - registered PC+4 of that instruction
//   ifid_valid        - ifid_instruction is a real fetched word
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    fetch_state_e state, state_next;
    logic [31:0]  pc_q, pc_next;
    fetch_word_t  skid, skid_next;
    fetch_word_t  ifid_din;
    logic         ifid_load, ifid_flush;
    logic         started;      // low until the first edge after reset
    logic         fetch_ack;
    logic [31:0]  pc_plus4;
    logic         unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target[1:0];

    // The request is held off for one edge after reset so that it rises on
    // the first clock edge rather than combinationally with reset release.
    assign imem_req  = started && (state == ST_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign fetch_ack = imem_req && imem_ack;
    assign pc_plus4  = pc_q + 32'd4;   // modulo 2^32 wrap is intended

    // NOTE: the skid register is reset along with the control state; it is
    // only two words, and a known value keeps a discarded entry deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            pc_q    <= RESET_VECTOR;
            skid    <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            skid    <= skid_next;
            started <= 1'b1;
        end
    end

    // NOTE: every output of this block is given a default first so that no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next           = state;
        pc_next              = pc_q;
        skid_next            = skid;
        ifid_load            = 1'b0;
        ifid_flush           = 1'b0;
        ifid_din.instruction = imem_data;
        ifid_din.pc_plus4    = pc_plus4;

        if (branch_taken) begin
            // Redirect beats stall and ack; a same-cycle ack is dropped.
            pc_next    = {branch_target[31:2], 2'b00};
            skid_next  = '0;
            ifid_flush = 1'b1;
            state_next = ST_FETCH;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (fetch_ack) begin
                        pc_next = pc_plus4;
                        if (stall) begin
                            skid_next.instruction = imem_data;
                            skid_next.pc_plus4    = pc_plus4;
                            state_next            = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;   // bubble while waiting on memory
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_din   = skid;
                        ifid_load  = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
                default: state_next = ST_FETCH;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .din         (ifid_din),
        .instruction (ifid_instruction),
        .pc_plus4    (ifid_pc_plus4),
        .valid       (ifid_valid)
    );

endmodule
